// File: rtl/seq_divider.sv
// seq_divider -- multi-cycle RV32M divide unit (DIV, DIVU, REM, REMU).
//
// Radix-2 restoring division over operand magnitudes, one quotient bit per
// clock, followed by a sign fix-up cycle. Fixed latency: valid_o is high in
// the cycle after the 34th rising edge, counting the edge that accepted
// start_i as edge 1.
//
// Optional feature (macro DIV_EARLY_OUT_EN): divide-by-zero and signed
// overflow skip the iteration loop. IDLE -> DONE on the start edge,
// busy_o high for one cycle, and valid_o high in the cycle after the 2nd edge.
// With the macro undefined these cases take the normal 34-edge path and
// produce the same results.
//
// Ports:
//   clk_i        in   rising-edge clock
//   rst_ni       in   asynchronous active-low reset
//   start_i      in   request, sampled only in IDLE
//   op_i[1:0]    in   00 DIV, 01 DIVU, 10 REM, 11 REMU
//   operand_a_i  in   dividend (rs1)
//   operand_b_i  in   divisor (rs2)
//   flush_i      in   abort the in-flight operation
//   busy_o       out  high whenever the FSM is not in IDLE
//   valid_o      out  one-cycle pulse, result_o is valid in this cycle
//   result_o     out  quotient or remainder, held until the next result
//   dbg_state_o  out  current FSM state (IDLE=0, CALC=1, FIX=2, DONE=3)
//
// Handshake: a request is accepted on a rising edge where start_i=1,
// flush_i=0 and the unit is in IDLE (busy_o=0). While busy_o=1, start_i is
// ignored and nothing is queued. Every accepted request that is not flushed
// produces exactly one valid_o pulse. flush_i while busy returns to IDLE on
// the next edge without a pulse and leaves result_o unchanged.

module seq_divider #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] operand_a_i,
  input  logic [XLEN-1:0] operand_b_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [1:0]      dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] OP_DIV = 2'b00;
  localparam logic [1:0] OP_REM = 2'b10;

  state_t            state_q;
  logic [1:0]        op_q;
  logic [XLEN-1:0]   quo_q;   // dividend shifting out at the top, quotient bits shifting in at the bottom
  logic [XLEN-1:0]   div_q;   // divisor magnitude
  logic [XLEN-1:0]   rem_q;   // partial remainder
  logic [CNT_W-1:0]  cnt_q;
  logic              qs_q;    // quotient must be negated (DIV only)
  logic              rs_q;    // remainder must be negated (REM only)

  assign dbg_state_o = state_q;

  // Operand conditioning at accept time. A 32-bit negate of 0x8000_0000 is
  // 0x8000_0000, which is the correct magnitude when read as unsigned.
  logic            signed_op;
  logic            b_zero;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;

  assign signed_op = ~op_i[0];
  assign b_zero    = (operand_b_i == '0);
  assign abs_a     = (signed_op && operand_a_i[XLEN-1]) ? -operand_a_i : operand_a_i;
  assign abs_b     = (signed_op && operand_b_i[XLEN-1]) ? -operand_b_i : operand_b_i;

  // One restoring step. The shifted remainder needs XLEN+1 bits for the
  // compare. After a subtract it is always below the divisor, so the stored
  // remainder fits in XLEN bits.
  logic [XLEN:0]   rem_shift;
  logic            rem_ge;
  logic [XLEN-1:0] rem_sub;

  assign rem_shift = {rem_q, quo_q[XLEN-1]};
  assign rem_ge    = (rem_shift >= {1'b0, div_q});
  assign rem_sub   = rem_shift[XLEN-1:0] - div_q;

  // Sign fix-up. With a zero divisor the loop yields Q = all ones and R = |a|.
  // qs is cleared for that case so DIV keeps all ones, and negating R restores
  // the original dividend for REM.
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;

  assign quo_fix = (op_q == OP_DIV && qs_q) ? -quo_q : quo_q;
  assign rem_fix = (op_q == OP_REM && rs_q) ? -rem_q : rem_q;

`ifdef DIV_EARLY_OUT_EN
  logic            early_q;
  logic            ovf;
  logic            special;
  logic [XLEN-1:0] special_res;

  assign ovf         = signed_op && (operand_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (operand_b_i == '1);
  assign special     = b_zero || ovf;
  // Overflow: quotient is the dividend itself (0x8000_0000) and remainder is 0.
  assign special_res = b_zero ? (op_i[1] ? operand_a_i : '1)
                              : (op_i[1] ? '0 : operand_a_i);
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      op_q     <= '0;
      quo_q    <= '0;
      div_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      qs_q     <= 1'b0;
      rs_q     <= 1'b0;
      busy_o   <= 1'b0;
      valid_o  <= 1'b0;
      result_o <= '0;
`ifdef DIV_EARLY_OUT_EN
      early_q  <= 1'b0;
`endif
    end else begin
      valid_o <= 1'b0;
      case (state_q)
        IDLE: begin
          // flush_i wins over a simultaneous start_i.
          if (start_i && !flush_i) begin
            op_q    <= op_i;
            quo_q   <= abs_a;
            div_q   <= abs_b;
            rem_q   <= '0;
            cnt_q   <= CNT_W'(XLEN - 1);
            qs_q    <= (operand_a_i[XLEN-1] ^ operand_b_i[XLEN-1]) & ~b_zero;
            rs_q    <= operand_a_i[XLEN-1];
            busy_o  <= 1'b1;
            state_q <= CALC;
`ifdef DIV_EARLY_OUT_EN
            if (special) begin
              // Park the answer in quo_q so a flush in DONE leaves result_o untouched.
              quo_q   <= special_res;
              early_q <= 1'b1;
              state_q <= DONE;
            end
`endif
          end
        end

        CALC: begin
          if (flush_i) begin
            busy_o  <= 1'b0;
            state_q <= IDLE;
          end else begin
            rem_q <= rem_ge ? rem_sub : rem_shift[XLEN-1:0];
            quo_q <= {quo_q[XLEN-2:0], rem_ge};
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == '0) begin
              state_q <= FIX;
            end
          end
        end

        FIX: begin
          if (flush_i) begin
            busy_o  <= 1'b0;
            state_q <= IDLE;
          end else begin
            result_o <= op_q[1] ? rem_fix : quo_fix;
            valid_o  <= 1'b1;
            state_q  <= DONE;
          end
        end

        DONE: begin
          busy_o  <= 1'b0;
          state_q <= IDLE;
`ifdef DIV_EARLY_OUT_EN
          // Early-out results are published on the DONE -> IDLE edge.
          if (early_q && !flush_i) begin
            result_o <= quo_q;
            valid_o  <= 1'b1;
          end
          early_q <= 1'b0;
`endif
        end

        default: begin
          busy_o  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
